rls_sample_sequencer: RTL and testbench
=======================================

Name: rls_sample_sequencer

Overview:
Parametrised sample/result sequencer for the RLS experiment harness. It generates sample-memory addresses on RLS advance requests and registers the returned samples. It also supplies the row index used by the A/K row selectors, and buffers RLS results in a first-word-fall-through FIFO with a valid/ready drain port. Compared with the fixed free-running counter arrangement, it adds start/abort control, single-pass or continuous modes, pass counting, and lossless result capture with overflow detection.

Parameters:
nBits, 32, sample and result word width
M, 32, rows per pass; iteration runs 0..M-1
B, 1024, samples per row; a pass is M*B samples
ADDR_W, 15, sample address width; must satisfy 2^ADDR_W >= M*B
FIFO_DEPTH, 16, result FIFO depth; power of two, >= 2

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-low; asserting it (low) clears all state immediately
start  in  1  one-cycle pulse; begins a run
mode  in  1  sampled at start; 0 = single pass, 1 = continuous wrap
abort  in  1  one-cycle pulse; stops the run and flushes the FIFO
encounter  in  1  advance request from the RLS core; consume one sample
write  in  1  result strobe from the RLS core
x  in  nBits  result word, valid with write
mem_addr  out  ADDR_W  sample memory address; memory read latency is 1 cycle
mem_rdata  in  nBits  sample memory data
y  out  nBits  registered sample to the RLS core
y_valid  out  1  one-cycle pulse when y is updated
iteration  out  32  current row index = mem_addr / B, zero-extended
busy  out  1  high in RUN and DRAIN
done  out  1  high in DONE
pass_count  out  16  completed passes; wraps modulo 2^16
res_data  out  nBits  FIFO head
res_valid  out  1  FIFO not empty
res_ready  in  1  consumer pop
res_count  out  32  results accepted since start; saturates at all-ones
overflow  out  1  sticky; a result was dropped

Behaviour:
- Reset values: all outputs 0; state IDLE; FIFO empty.
- States:
  - IDLE: start -> RUN.
  - RUN: end of a single pass -> DRAIN.
  - DRAIN: FIFO empty -> DONE.
  - DONE: start -> RUN.
  - start is ignored in RUN and DRAIN.
- On start:
  - mem_addr = 0 and iteration = 0.
  - pass_count, res_count and overflow cleared; FIFO flushed.
  - mode latched.
- Sample timing:
  - In RUN, the cycle after start, or after an accepted encounter, issues a read (the first cycle after start reads address 0).
  - The address update cycle is t. y is loaded from mem_rdata at t+2, and y_valid pulses for that one cycle.
  - An encounter arriving while a read is in flight is still accepted. Addresses advance once per encounter; y follows in order.
- Address and row rules:
  - Each accepted encounter increments mem_addr.
  - iteration increments when mem_addr crosses a multiple of B.
  - At mem_addr = M*B-1, an encounter completes the pass and pass_count increments.
    - mode 0: mem_addr holds; state -> DRAIN; further encounters are ignored.
    - mode 1: mem_addr and iteration wrap to 0; RUN continues.
- Result capture:
  - write is accepted in RUN and DRAIN only.
  - If the FIFO is not full, x is pushed and res_count increments.
  - If full, x is dropped and overflow is set. The exception is a simultaneous pop (res_valid && res_ready), which frees a slot, so the push is accepted.
  - A pop with the FIFO empty is ignored. A simultaneous push and pop when empty makes the pushed word the head next cycle.
- abort in any non-IDLE state:
  - Next state is IDLE; FIFO flushed.
  - y_valid is suppressed, including any read in flight.
  - pass_count, res_count and overflow hold until the next start.
  - abort has priority over start, encounter and write in the same cycle.
- Reset mid-operation: immediate return to reset values; no partial result is preserved.

Test Plan:
- M=2, B=4, mode 0: start, then 8 encounter pulses spaced 3 cycles apart -> mem_addr sequence 0..7; iteration 0,0,0,0,1,1,1,1; y_valid 2 cycles after each address update; pass_count=1; DRAIN then DONE with an empty FIFO.
- mode 1, same parameters, 20 encounters -> mem_addr wraps 7->0 twice; pass_count=2; mem_addr=4; iteration=1; busy stays 1.
- FIFO_DEPTH=4, res_ready=0: 6 write pulses with x=1..6 -> res_count=4; overflow=1; then draining yields 1,2,3,4 in order.
- FIFO full: write with x=9 in the same cycle as a pop -> push accepted; overflow stays 0; res_count increments.
- Abort mid-RUN at mem_addr=5 with 2 results buffered -> IDLE next cycle; res_valid=0; no y_valid from the in-flight read; res_count=2 retained; a subsequent start clears the counters.
- Reset pulled low mid-DRAIN -> all outputs 0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/rls_sample_sequencer.sv
// rls_sample_sequencer
//   Sample/result sequencer for the RLS experiment harness. Walks the sample
//   memory one address per RLS advance request, returns the read sample as a
//   registered y with a one-cycle y_valid pulse, tracks the row index for the
//   A/K row selectors, and buffers RLS results in a first-word-fall-through
//   FIFO drained through a valid/ready port.
//
// Ports
//   clk, reset      : clock, asynchronous active-low reset
//   start, mode     : begin a run; mode 0 = single pass, 1 = continuous wrap
//   abort           : stop the run, flush the FIFO, suppress pending samples
//   encounter       : advance request (consume one sample)
//   write, x        : result strobe and result word
//   mem_addr        : sample address (1-cycle read latency memory)
//   mem_rdata       : sample memory data
//   y, y_valid      : registered sample and its update pulse
//   iteration       : row index (mem_addr / B)
//   busy, done      : RUN/DRAIN indication, DONE indication
//   pass_count      : completed passes, modulo 2^16
//   res_data/valid  : FIFO head and not-empty flag
//   res_ready       : consumer pop
//   res_count       : results accepted since start, saturating
//   overflow        : sticky dropped-result flag
module rls_sample_sequencer #(
  parameter int nBits      = 32,
  parameter int M          = 32,
  parameter int B          = 1024,
  parameter int ADDR_W     = 15,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic              abort,
  input  logic              encounter,
  input  logic              write,
  input  logic [nBits-1:0]  x,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [nBits-1:0]  mem_rdata,
  output logic [nBits-1:0]  y,
  output logic              y_valid,
  output logic [31:0]       iteration,
  output logic              busy,
  output logic              done,
  output logic [15:0]       pass_count,
  output logic [nBits-1:0]  res_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_count,
  output logic              overflow
);

  localparam int                PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(M * B - 1);
  localparam logic [31:0]       LAST_COL  = 32'(B - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        col_q, col_d;
  logic [31:0]        iter_q, iter_d;
  logic [15:0]        pass_q, pass_d;
  logic               rd_p1_q, rd_p1_d;
  logic               rd_p2_q, rd_p2_d;
  logic [nBits-1:0]   y_q, y_d;
  logic               y_vld_q, y_vld_d;
  logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
  logic [31:0]        res_cnt_q, res_cnt_d;
  logic               ovf_q, ovf_d;
  logic [nBits-1:0]   fifo_mem [FIFO_DEPTH];

  logic fifo_empty, fifo_full, active, abort_go, start_go;
  logic pop, wr_req, push, drop, adv, last;

  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    // Extra pointer bit distinguishes full from empty when the indices match.
    fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    active     = (state_q == S_RUN) || (state_q == S_DRAIN);
    abort_go   = abort && (state_q != S_IDLE);
    start_go   = start && !abort && ((state_q == S_IDLE) || (state_q == S_DONE));
    pop        = !fifo_empty && res_ready && !abort_go;
    wr_req     = write && active && !abort_go;
    // A same-cycle pop frees the slot the push needs.
    push       = wr_req && (!fifo_full || pop);
    drop       = wr_req && fifo_full && !pop;
    adv        = (state_q == S_RUN) && encounter && !abort_go;
    last       = (addr_q == LAST_ADDR);
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    addr_d    = addr_q;
    col_d     = col_q;
    iter_d    = iter_q;
    pass_d    = pass_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    res_cnt_d = res_cnt_q;
    ovf_d     = ovf_q;
    // p0 -> p1: a read is issued on every address update
    rd_p1_d   = 1'b0;
    // p1 -> p2: memory data returns one cycle after the address
    rd_p2_d   = rd_p1_q;
    // p2 -> output: sample registered with its valid pulse
    y_vld_d   = rd_p2_q;
    y_d       = rd_p2_q ? mem_rdata : y_q;

    if (abort_go) begin
      state_d  = S_IDLE;
      rd_p2_d  = 1'b0;
      y_vld_d  = 1'b0;
      y_d      = y_q;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else if (start_go) begin
      state_d   = S_RUN;
      mode_d    = mode;
      addr_d    = '0;
      col_d     = '0;
      iter_d    = '0;
      pass_d    = '0;
      res_cnt_d = '0;
      ovf_d     = 1'b0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      rd_p1_d   = 1'b1;
    end else begin
      if (adv) begin
        if (last) begin
          pass_d = pass_q + 16'd1;
          if (mode_q) begin
            addr_d  = '0;
            col_d   = '0;
            iter_d  = '0;
            rd_p1_d = 1'b1;
          end else begin
            state_d = S_DRAIN;
          end
        end else begin
          addr_d  = addr_q + 1'b1;
          rd_p1_d = 1'b1;
          // Column counter avoids a divider for the row index.
          if (col_q == LAST_COL) begin
            col_d  = '0;
            iter_d = iter_q + 32'd1;
          end else begin
            col_d  = col_q + 32'd1;
          end
        end
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (res_cnt_q != '1) res_cnt_d = res_cnt_q + 32'd1;
      end
      if (drop) ovf_d = 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if ((state_q == S_DRAIN) && fifo_empty && !push) state_d = S_DONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      mode_q    <= 1'b0;
      addr_q    <= '0;
      col_q     <= '0;
      iter_q    <= '0;
      pass_q    <= '0;
      rd_p1_q   <= 1'b0;
      rd_p2_q   <= 1'b0;
      y_q       <= '0;
      y_vld_q   <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      res_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      addr_q    <= addr_d;
      col_q     <= col_d;
      iter_q    <= iter_d;
      pass_q    <= pass_d;
      rd_p1_q   <= rd_p1_d;
      rd_p2_q   <= rd_p2_d;
      y_q       <= y_d;
      y_vld_q   <= y_vld_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      res_cnt_q <= res_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage is not reset; the head is masked to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= x;
  end

  assign mem_addr   = addr_q;
  assign y          = y_q;
  assign y_valid    = y_vld_q;
  assign iteration  = iter_q;
  assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);
  assign pass_count = pass_q;
  assign res_valid  = !fifo_empty;
  assign res_data   = fifo_empty ? '0 : fifo_mem[rd_ptr_q[PTR_W-1:0]];
  assign res_count  = res_cnt_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_rls_sample_sequencer.sv
// tb_rls_sample_sequencer
//   Directed bench for rls_sample_sequencer with M=2, B=4, FIFO_DEPTH=4.
//   A behavioural sample memory returns 0xA000 + address one cycle after the
//   address is presented.
module tb_rls_sample_sequencer;

  localparam int NB = 32;
  localparam int M  = 2;
  localparam int B  = 4;
  localparam int AW = 3;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, mode, abort, encounter, write, res_ready;
  logic [NB-1:0] x;
  logic [AW-1:0] mem_addr;
  logic [NB-1:0] mem_rdata = '0;
  logic [NB-1:0] y;
  logic          y_valid;
  logic [31:0]   iteration;
  logic          busy, done;
  logic [15:0]   pass_count;
  logic [NB-1:0] res_data;
  logic          res_valid;
  logic [31:0]   res_count;
  logic          overflow;

  int n_checks = 0;
  int n_fail   = 0;

  rls_sample_sequencer #(
    .nBits(NB), .M(M), .B(B), .ADDR_W(AW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset(rst_n), .start(start), .mode(mode), .abort(abort),
    .encounter(encounter), .write(write), .x(x), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .y(y), .y_valid(y_valid), .iteration(iteration),
    .busy(busy), .done(done), .pass_count(pass_count), .res_data(res_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_count(res_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= 32'hA000 + 32'(mem_addr);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string pfx);
    check_eq({pfx, "_mem_addr"},   32'(mem_addr),   32'd0);
    check_eq({pfx, "_y"},          y,               32'd0);
    check_eq({pfx, "_y_valid"},    32'(y_valid),    32'd0);
    check_eq({pfx, "_iteration"},  iteration,       32'd0);
    check_eq({pfx, "_busy"},       32'(busy),       32'd0);
    check_eq({pfx, "_done"},       32'(done),       32'd0);
    check_eq({pfx, "_pass_count"}, 32'(pass_count), 32'd0);
    check_eq({pfx, "_res_valid"},  32'(res_valid),  32'd0);
    check_eq({pfx, "_res_data"},   res_data,        32'd0);
    check_eq({pfx, "_res_count"},  res_count,       32'd0);
    check_eq({pfx, "_overflow"},   32'(overflow),   32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp4 [4];
    int          yv_cnt;
    rst_n = 1'b0; start = 0; mode = 0; abort = 0; encounter = 0;
    write = 0; res_ready = 0; x = '0;
    #3;
    check_zero("reset");
    tick; tick;
    rst_n = 1'b1;
    tick;

    // Single pass, encounters spaced three cycles apart
    mode = 1'b0; start = 1'b1; tick; start = 1'b0;
    check_eq("t1_addr0", 32'(mem_addr), 32'd0);
    check_eq("t1_busy",  32'(busy), 32'd1);
    check_eq("t1_yv_t0", 32'(y_valid), 32'd0);
    tick;
    check_eq("t1_yv_t1", 32'(y_valid), 32'd0);
    tick;
    check_eq("t1_yv_t2", 32'(y_valid), 32'd1);
    check_eq("t1_y0",    y, 32'hA000);
    for (int i = 1; i <= 8; i++) begin
      encounter = 1'b1; tick; encounter = 1'b0;
      if (i < 8) begin
        check_eq("t1_addr", 32'(mem_addr), 32'(i));
        check_eq("t1_iter", iteration, 32'(i / B));
        check_eq("t1_yv_a", 32'(y_valid), 32'd0);
        tick;
        check_eq("t1_yv_b", 32'(y_valid), 32'd0);
        tick;
        check_eq("t1_yv_c", 32'(y_valid), 32'd1);
        check_eq("t1_y",    y, 32'hA000 + 32'(i));
      end else begin
        check_eq("t1_addr_hold", 32'(mem_addr), 32'd7);
        check_eq("t1_pass",      32'(pass_count), 32'd1);
        check_eq("t1_drain_busy", 32'(busy), 32'd1);
        check_eq("t1_drain_done", 32'(done), 32'd0);
        tick;
        check_eq("t1_done",      32'(done), 32'd1);
        check_eq("t1_done_busy", 32'(busy), 32'd0);
        tick;
        check_eq("t1_no_last_yv", 32'(y_valid), 32'd0);
        check_eq("t1_fifo_empty", 32'(res_valid), 32'd0);
      end
    end

    // Continuous mode, 20 back-to-back encounters
    mode = 1'b1; start = 1'b1; tick; start = 1'b0;
    yv_cnt = 0;
    for (int k = 1; k <= 23; k++) begin
      encounter = (k <= 20);
      tick;
      if (y_valid) yv_cnt++;
      if (k == 8) begin
        check_eq("t2_wrap1_addr", 32'(mem_addr), 32'd0);
        check_eq("t2_wrap1_pass", 32'(pass_count), 32'd1);
        check_eq("t2_wrap1_iter", iteration, 32'd0);
      end
      if (k == 20) begin
        check_eq("t2_addr", 32'(mem_addr), 32'd4);
        check_eq("t2_iter", iteration, 32'd1);
        check_eq("t2_pass", 32'(pass_count), 32'd2);
      end
    end
    encounter = 1'b0;
    check_eq("t2_yv_count", 32'(yv_cnt), 32'd21);
    check_eq("t2_y_last",   y, 32'hA004);
    check_eq("t2_busy",     32'(busy), 32'd1);
    abort = 1'b1; tick; abort = 1'b0;
    check_eq("t2_abort_busy", 32'(busy), 32'd0);
    check_eq("t2_pass_held",  32'(pass_count), 32'd2);

    // FIFO overflow with consumer stalled
    mode = 1'b0; start = 1'b1; tick; start = 1'b0;
    check_eq("t3_pass_clr", 32'(pass_count), 32'd0);
    for (int k = 1; k <= 6; k++) begin
      write = 1'b1; x = 32'(k); tick;
    end
    write = 1'b0;
    check_eq("t3_res_count", res_count, 32'd4);
    check_eq("t3_overflow",  32'(overflow), 32'd1);
    check_eq("t3_res_valid", 32'(res_valid), 32'd1);
    res_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check_eq("t3_drain", res_data, 32'(k));
      tick;
    end
    res_ready = 1'b0;
    check_eq("t3_empty", 32'(res_valid), 32'd0);

    // Push into a full FIFO alongside a pop
    abort = 1'b1; tick; abort = 1'b0;
    check_eq("t4_ovf_held", 32'(overflow), 32'd1);
    start = 1'b1; tick; start = 1'b0;
    check_eq("t4_ovf_clr", 32'(overflow), 32'd0);
    check_eq("t4_cnt_clr", res_count, 32'd0);
    for (int k = 0; k < 4; k++) begin
      write = 1'b1; x = 32'(11 + k); tick;
    end
    write = 1'b1; x = 32'd9; res_ready = 1'b1; tick; write = 1'b0;
    check_eq("t4_overflow", 32'(overflow), 32'd0);
    check_eq("t4_res_count", res_count, 32'd5);
    exp4[0] = 32'd12; exp4[1] = 32'd13; exp4[2] = 32'd14; exp4[3] = 32'd9;
    for (int k = 0; k < 4; k++) begin
      check_eq("t4_drain", res_data, exp4[k]);
      tick;
    end
    res_ready = 1'b0;
    check_eq("t4_empty", 32'(res_valid), 32'd0);

    // Abort with a read in flight and two buffered results
    abort = 1'b1; tick; abort = 1'b0;
    start = 1'b1; tick; start = 1'b0;
    encounter = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      write = (k <= 2); x = 32'(20 + k); tick;
    end
    encounter = 1'b0; write = 1'b0;
    check_eq("t5_addr", 32'(mem_addr), 32'd5);
    check_eq("t5_cnt_pre", res_count, 32'd2);
    abort = 1'b1; tick; abort = 1'b0;
    check_eq("t5_busy", 32'(busy), 32'd0);
    check_eq("t5_done", 32'(done), 32'd0);
    check_eq("t5_res_valid", 32'(res_valid), 32'd0);
    check_eq("t5_res_count", res_count, 32'd2);
    check_eq("t5_yv0", 32'(y_valid), 32'd0);
    tick;
    check_eq("t5_yv1", 32'(y_valid), 32'd0);
    tick;
    check_eq("t5_yv2", 32'(y_valid), 32'd0);
    start = 1'b1; tick; start = 1'b0;
    check_eq("t5_restart_cnt",  res_count, 32'd0);
    check_eq("t5_restart_addr", 32'(mem_addr), 32'd0);

    // Asynchronous reset while draining
    encounter = 1'b1; write = 1'b1; x = 32'd7; tick; write = 1'b0;
    for (int k = 2; k <= 8; k++) tick;
    encounter = 1'b0;
    check_eq("t6_pass", 32'(pass_count), 32'd1);
    check_eq("t6_busy", 32'(busy), 32'd1);
    check_eq("t6_addr", 32'(mem_addr), 32'd7);
    check_eq("t6_res_valid", 32'(res_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_zero("t6_async");
    tick;
    rst_n = 1'b1;
    tick;
    check_eq("t6_post_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
